// File: rtl/lsu_pkg.sv
// Shared constants and types for the load/store control stage.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [1:0] LEN_B = 2'b00;
  localparam logic [1:0] LEN_H = 2'b01;
  localparam logic [1:0] LEN_W = 2'b10;

  typedef enum logic [1:0] {
    StIdle,
    StAccess,
    StResp
  } lsu_state_e;

endpackage

// File: rtl/lsu_decode.sv
// Combinational decode of funct3 into length/sign, plus alignment and range fault checks.
module lsu_decode
  import lsu_pkg::*;
#(
  parameter int unsigned ADDR_BITS = 16
) (
  input  logic [2:0]  funct3_i,
  input  logic [31:0] addr_i,
  input  logic        wr_i,
  output logic [1:0]  length_o,
  output logic        sign_o,
  output logic        fault_o
);

  logic illegal, misaligned, out_of_range;

  assign length_o = funct3_i[1:0];
  assign sign_o   = (funct3_i == F3_B) || (funct3_i == F3_H);

  // Unsigned variants exist only for byte/half loads.
  assign illegal = (funct3_i[1:0] == 2'b11) ||
                   (funct3_i[2] && (wr_i || (funct3_i[1:0] == LEN_W)));

  assign misaligned = ((funct3_i[1:0] == LEN_H) && addr_i[0]) ||
                      ((funct3_i[1:0] == LEN_W) && (addr_i[1:0] != 2'b00));

  assign out_of_range = (addr_i >> ADDR_BITS) != 32'd0;

  assign fault_o = illegal || misaligned || out_of_range;

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store control: accepts one request, runs a timed memory access, pulses a response.
module lsu_ctrl
  import lsu_pkg::*;
#(
  parameter int unsigned MEM_LATENCY = 1,
  parameter int unsigned ADDR_BITS   = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_wr_i,
  input  logic [2:0]  req_funct3_i,
  input  logic [31:0] req_addr_i,
  input  logic [31:0] req_wdata_i,
  output logic        stall_o,
  output logic        resp_valid_o,
  output logic        resp_fault_o,
  output logic [31:0] resp_rdata_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  output logic [1:0]  mem_length_o,
  output logic        mem_sign_o,
  output logic        mem_enable_o,
  output logic        mem_wr_o,
  input  logic [31:0] mem_rdata_i
);

  localparam int unsigned CntW = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
  localparam logic [CntW-1:0] CntInit = CntW'(MEM_LATENCY - 1);

  lsu_state_e      state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            wr_q, wr_d;
  logic [31:0]     addr_q, addr_d;
  logic [31:0]     wdata_q, wdata_d;
  logic [1:0]      len_q, len_d;
  logic            sign_q, sign_d;
  logic            fault_q, fault_d;
  logic [31:0]     rdata_q, rdata_d;

  logic [1:0] dec_length;
  logic       dec_sign, dec_fault;
  logic       accept, in_access;

  lsu_decode #(
    .ADDR_BITS (ADDR_BITS)
  ) u_decode (
    .funct3_i (req_funct3_i),
    .addr_i   (req_addr_i),
    .wr_i     (req_wr_i),
    .length_o (dec_length),
    .sign_o   (dec_sign),
    .fault_o  (dec_fault)
  );

  assign in_access   = (state_q == StAccess);
  assign req_ready_o = ~in_access;
  assign accept      = req_valid_i & req_ready_o;
  assign stall_o     = req_valid_i & ~req_ready_o;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wr_d    = wr_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    len_d   = len_q;
    sign_d  = sign_q;
    fault_d = fault_q;
    rdata_d = rdata_q;
    unique case (state_q)
      StAccess: begin
        if (cnt_q == '0) begin
          rdata_d = wr_q ? 32'd0 : mem_rdata_i;
          state_d = StResp;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      StResp: state_d = StIdle;
      default: state_d = StIdle;
    endcase
    // Accept is possible from Idle and Resp; it overrides the Resp->Idle return.
    if (accept) begin
      wr_d    = req_wr_i;
      addr_d  = req_addr_i;
      wdata_d = req_wdata_i;
      len_d   = dec_length;
      sign_d  = dec_sign;
      fault_d = dec_fault;
      rdata_d = 32'd0;
      cnt_d   = CntInit;
      state_d = dec_fault ? StResp : StAccess;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      wr_q    <= 1'b0;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      len_q   <= 2'b00;
      sign_q  <= 1'b0;
      fault_q <= 1'b0;
      rdata_q <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wr_q    <= wr_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      len_q   <= len_d;
      sign_q  <= sign_d;
      fault_q <= fault_d;
      rdata_q <= rdata_d;
    end
  end

  assign resp_valid_o = (state_q == StResp);
  assign resp_fault_o = resp_valid_o & fault_q;
  assign resp_rdata_o = resp_valid_o ? rdata_q : 32'd0;

  assign mem_enable_o = in_access;
  // Write only in the last access cycle so the memory sees a single write edge.
  assign mem_wr_o     = in_access & wr_q & (cnt_q == '0);
  assign mem_addr_o   = in_access ? addr_q : 32'd0;
  assign mem_wdata_o  = in_access ? wdata_q : 32'd0;
  assign mem_length_o = in_access ? len_q : 2'b00;
  assign mem_sign_o   = in_access & sign_q;

endmodule

// File: tb/tb_lsu_ctrl.sv
// Directed bench: one stage with single-cycle memory, one with three-cycle memory.
module tb_lsu_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        wr;
  logic [2:0]  f3;
  logic [31:0] addr, wdata;
  logic        v1, v3;

  logic        rdy1, stall1, rv1, rf1, ms1, me1, mw1;
  logic [31:0] rd1, ma1, mwd1, mrd1;
  logic [1:0]  ml1;
  logic        rdy3, stall3, rv3, rf3, ms3, me3, mw3;
  logic [31:0] rd3, ma3, mwd3, mrd3;
  logic [1:0]  ml3;

  logic [7:0] m1 [65536];
  logic [7:0] m3 [65536];

  int checks = 0;
  int failures = 0;
  int wr1 = 0, en1 = 0, wr3 = 0, rsp3 = 0;

  always #5 clk = ~clk;

  lsu_ctrl #(.MEM_LATENCY(1), .ADDR_BITS(16)) u_dut1 (
    .clk (clk), .rst (rst),
    .req_valid_i (v1), .req_ready_o (rdy1), .req_wr_i (wr), .req_funct3_i (f3),
    .req_addr_i (addr), .req_wdata_i (wdata), .stall_o (stall1),
    .resp_valid_o (rv1), .resp_fault_o (rf1), .resp_rdata_o (rd1),
    .mem_addr_o (ma1), .mem_wdata_o (mwd1), .mem_length_o (ml1), .mem_sign_o (ms1),
    .mem_enable_o (me1), .mem_wr_o (mw1), .mem_rdata_i (mrd1)
  );

  lsu_ctrl #(.MEM_LATENCY(3), .ADDR_BITS(16)) u_dut3 (
    .clk (clk), .rst (rst),
    .req_valid_i (v3), .req_ready_o (rdy3), .req_wr_i (wr), .req_funct3_i (f3),
    .req_addr_i (addr), .req_wdata_i (wdata), .stall_o (stall3),
    .resp_valid_o (rv3), .resp_fault_o (rf3), .resp_rdata_o (rd3),
    .mem_addr_o (ma3), .mem_wdata_o (mwd3), .mem_length_o (ml3), .mem_sign_o (ms3),
    .mem_enable_o (me3), .mem_wr_o (mw3), .mem_rdata_i (mrd3)
  );

  function automatic logic [31:0] mem_rd(input logic [31:0] w, input logic [1:0] len,
                                         input logic sgn);
    case (len)
      2'b00:   return {{24{sgn & w[7]}}, w[7:0]};
      2'b01:   return {{16{sgn & w[15]}}, w[15:0]};
      default: return w;
    endcase
  endfunction

  // Little-endian byte memories: combinational read, write on falling edge.
  assign mrd1 = mem_rd({m1[ma1[15:0] + 16'd3], m1[ma1[15:0] + 16'd2],
                        m1[ma1[15:0] + 16'd1], m1[ma1[15:0]]}, ml1, ms1);
  assign mrd3 = mem_rd({m3[ma3[15:0] + 16'd3], m3[ma3[15:0] + 16'd2],
                        m3[ma3[15:0] + 16'd1], m3[ma3[15:0]]}, ml3, ms3);

  always @(negedge clk) begin
    if (me1 && mw1) begin
      m1[ma1[15:0]] <= mwd1[7:0];
      if (ml1 != 2'b00) m1[ma1[15:0] + 16'd1] <= mwd1[15:8];
      if (ml1 == 2'b10) begin
        m1[ma1[15:0] + 16'd2] <= mwd1[23:16];
        m1[ma1[15:0] + 16'd3] <= mwd1[31:24];
      end
    end
    if (me3 && mw3) begin
      m3[ma3[15:0]] <= mwd3[7:0];
      if (ml3 != 2'b00) m3[ma3[15:0] + 16'd1] <= mwd3[15:8];
      if (ml3 == 2'b10) begin
        m3[ma3[15:0] + 16'd2] <= mwd3[23:16];
        m3[ma3[15:0] + 16'd3] <= mwd3[31:24];
      end
    end
  end

  always @(negedge clk) begin
    if (mw1) wr1 <= wr1 + 1;
    if (me1) en1 <= en1 + 1;
    if (mw3) wr3 <= wr3 + 1;
    if (rv3) rsp3 <= rsp3 + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic req(input logic w, input logic [2:0] f, input logic [31:0] a,
                     input logic [31:0] d);
    wr = w; f3 = f; addr = a; wdata = d;
  endtask

  task automatic load1(input string tag, input logic [2:0] f, input logic [31:0] a,
                       input logic [1:0] len, input logic sgn, input logic [31:0] exp);
    req(1'b0, f, a, 32'd0);
    v1 = 1'b1;
    tick();
    chk({tag, "_en"}, {31'd0, me1}, 32'd1);
    chk({tag, "_len"}, {30'd0, ml1}, {30'd0, len});
    chk({tag, "_sign"}, {31'd0, ms1}, {31'd0, sgn});
    v1 = 1'b0;
    tick();
    chk({tag, "_rv"}, {31'd0, rv1}, 32'd1);
    chk({tag, "_rf"}, {31'd0, rf1}, 32'd0);
    chk({tag, "_rdata"}, rd1, exp);
    tick();
  endtask

  task automatic fault1(input string tag, input logic w, input logic [2:0] f,
                        input logic [31:0] a);
    int en_base;
    en_base = en1;
    req(w, f, a, 32'hA5A5A5A5);
    v1 = 1'b1;
    tick();
    chk({tag, "_rv"}, {31'd0, rv1}, 32'd1);
    chk({tag, "_rf"}, {31'd0, rf1}, 32'd1);
    chk({tag, "_rdata"}, rd1, 32'd0);
    chk({tag, "_en"}, {31'd0, me1}, 32'd0);
    v1 = 1'b0;
    tick();
    chk({tag, "_rv_end"}, {31'd0, rv1}, 32'd0);
    chk({tag, "_en_cnt"}, en1, en_base);
  endtask

  initial begin
    int n;
    int wbase, rbase;
    rst = 1'b1; v1 = 1'b0; v3 = 1'b0;
    req(1'b0, 3'b000, 32'd0, 32'd0);
    #12;
    chk("rst_ready", {31'd0, rdy1}, 32'd1);
    chk("rst_resp", {29'd0, rv1, rf1, stall1}, 32'd0);
    chk("rst_mem", {29'd0, me1, mw1, ms1}, 32'd0);
    chk("rst_addr", ma1, 32'd0);
    chk("rst_rdata", rd1, 32'd0);
    rst = 1'b0;
    tick();

    // Single-cycle memory: word store then word load.
    wbase = wr1;
    req(1'b1, 3'b010, 32'h0000_0100, 32'hDEADBEEF);
    v1 = 1'b1;
    tick();
    chk("sw_en", {31'd0, me1}, 32'd1);
    chk("sw_wr", {31'd0, mw1}, 32'd1);
    chk("sw_addr", ma1, 32'h0000_0100);
    chk("sw_wdata", mwd1, 32'hDEADBEEF);
    chk("sw_len", {30'd0, ml1}, 32'd2);
    chk("sw_stall", {30'd0, stall1, rdy1}, 32'd2);
    v1 = 1'b0;
    tick();
    chk("sw_rv", {31'd0, rv1}, 32'd1);
    chk("sw_rdata", rd1, 32'd0);
    chk("sw_idle_mem", {30'd0, me1, mw1}, 32'd0);
    tick();
    chk("sw_wr_cnt", wr1 - wbase, 32'd1);

    load1("lw", 3'b010, 32'h0000_0100, 2'b10, 1'b0, 32'hDEADBEEF);
    load1("lb", 3'b000, 32'h0000_0103, 2'b00, 1'b1, 32'hFFFFFFDE);
    load1("lbu", 3'b100, 32'h0000_0103, 2'b00, 1'b0, 32'h000000DE);
    load1("lhu", 3'b101, 32'h0000_0102, 2'b01, 1'b0, 32'h0000DEAD);

    fault1("f_lw_mis", 1'b0, 3'b010, 32'h0000_0102);
    fault1("f_lh_mis", 1'b0, 3'b001, 32'h0000_0101);
    fault1("f_lw_range", 1'b0, 3'b010, 32'h0001_0000);
    fault1("f_st_bu", 1'b1, 3'b100, 32'h0000_0100);

    // Three-cycle memory: sw then lw presented back to back.
    wbase = wr3;
    req(1'b1, 3'b010, 32'h0000_0010, 32'h12345678);
    v3 = 1'b1;
    tick();
    req(1'b0, 3'b010, 32'h0000_0010, 32'd0);
    n = 0;
    for (int i = 0; i < 3; i++) begin
      if (stall3 && me3) n++;
      tick();
    end
    chk("b2b_sw_stall_cycles", n, 32'd3);
    chk("b2b_sw_rv", {31'd0, rv3}, 32'd1);
    chk("b2b_sw_ready", {30'd0, rdy3, stall3}, 32'd2);
    chk("b2b_sw_rdata", rd3, 32'd0);
    tick();
    v3 = 1'b1;
    n = 0;
    for (int i = 0; i < 3; i++) begin
      if (stall3 && me3 && !mw3) n++;
      tick();
    end
    v3 = 1'b0;
    chk("b2b_lw_stall_cycles", n, 32'd3);
    chk("b2b_lw_rv", {31'd0, rv3}, 32'd1);
    chk("b2b_lw_rf", {31'd0, rf3}, 32'd0);
    chk("b2b_lw_rdata", rd3, 32'h12345678);
    chk("b2b_wr_cnt", wr3 - wbase, 32'd1);
    tick();

    // Reset in the second access cycle of a store.
    wbase = wr3;
    rbase = rsp3;
    req(1'b1, 3'b010, 32'h0000_0020, 32'hCAFEF00D);
    v3 = 1'b1;
    tick();
    v3 = 1'b0;
    tick();
    chk("rst_mid_en_before", {31'd0, me3}, 32'd1);
    rst = 1'b1;
    #1;
    chk("rst_mid_en", {30'd0, me3, mw3}, 32'd0);
    chk("rst_mid_ready", {31'd0, rdy3}, 32'd1);
    #2;
    rst = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    chk("rst_mid_wr_cnt", wr3 - wbase, 32'd0);
    chk("rst_mid_rsp_cnt", rsp3 - rbase, 32'd0);
    chk("rst_mid_ready_after", {31'd0, rdy3}, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
